// File: rtl/ram_display_ctrl.sv
// Button-driven RAM address/write controller with a multiplexed
// hex 7-segment display of address and read data.
module ram_display_db #(
  parameter int CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, ARM, PRESSED, WAIT_REL
  } st_t;

  st_t st;
  logic [1:0] sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer ahead of the debounce FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st    <= IDLE;
      sync  <= '0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= 1'b0;
      unique case (st)
        IDLE: begin
          cnt <= '0;
          if (sync[1]) st <= ARM;
        end
        ARM: begin
          if (!sync[1]) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st    <= PRESSED;
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: st <= WAIT_REL;
        WAIT_REL: begin
          if (sync[1]) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            st  <= IDLE;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module ram_display_ctrl #(
  parameter int DIGITS      = 4,
  parameter int ADDR_W      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DB_CYCLES   = 200000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  we,
  input  logic                  dir,
  input  logic                  auto_inc,
  input  logic                  view_sel,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [4*DIGITS-1:0]   ram_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [4*DIGITS-1:0]   ram_wdata,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg
);
  localparam int DATA_W = 4 * DIGITS;
  localparam int HALF_W = 2 * DIGITS;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int RC_W   = $clog2(REFRESH_DIV + 1);

  logic step_p, we_p, inc_pend;
  logic [ADDR_W-1:0] addr_nx;

  ram_display_db #(.CYCLES(DB_CYCLES)) u_db_step (
    .clock(clock), .reset(reset), .raw(step), .pulse(step_p)
  );
  ram_display_db #(.CYCLES(DB_CYCLES)) u_db_we (
    .clock(clock), .reset(reset), .raw(we), .pulse(we_p)
  );

  assign addr_nx = dir ? ram_addr - ADDR_W'(1)
                       : ram_addr + ADDR_W'(1);

  // Write wins over step; a pending auto-increment swallows steps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      inc_pend  <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (we_p) begin
        ram_we    <= 1'b1;
        ram_wdata <= din;
        inc_pend  <= auto_inc;
      end else if (inc_pend) begin
        ram_addr <= addr_nx;
        inc_pend <= 1'b0;
      end else if (step_p && !ram_we) begin
        ram_addr <= addr_nx;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'h0: p = 7'h7E;
      4'h1: p = 7'h30;
      4'h2: p = 7'h6D;
      4'h3: p = 7'h79;
      4'h4: p = 7'h33;
      4'h5: p = 7'h5B;
      4'h6: p = 7'h5F;
      4'h7: p = 7'h70;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h7B;
      4'hA: p = 7'h77;
      4'hB: p = 7'h1F;
      4'hC: p = 7'h4E;
      4'hD: p = 7'h3D;
      4'hE: p = 7'h4F;
      4'hF: p = 7'h47;
    endcase
    return ~p;
  endfunction

  logic [RC_W-1:0]   rcnt;
  logic [IDX_W-1:0]  idx, nidx;
  logic              lit, wrap, new_frame;
  logic [DATA_W-1:0] frame, word, src;
  logic [3:0]        nib;

  always_comb begin
    word = {view_sel ? ram_rdata[DATA_W-1:HALF_W] : HALF_W'(ram_addr),
            ram_rdata[HALF_W-1:0]};
    wrap = rcnt == RC_W'(REFRESH_DIV - 1);
    nidx = '0;
    if (lit && idx != IDX_W'(DIGITS - 1)) nidx = idx + IDX_W'(1);
    new_frame = nidx == '0;
    src = new_frame ? word : frame;
    nib = src[{nidx, 2'b00} +: 4];
  end

  // Nothing is lit until the first wrap; each wrap lights the next digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt  <= '0;
      idx   <= '0;
      lit   <= 1'b0;
      frame <= '0;
      anode <= '1;
      seg   <= 7'h7F;
    end else if (wrap) begin
      rcnt  <= '0;
      idx   <= nidx;
      lit   <= 1'b1;
      if (new_frame) frame <= word;
      anode <= ~(DIGITS'(1) << nidx);
      seg   <= hex7(nib);
    end else begin
      rcnt <= rcnt + RC_W'(1);
    end
  end
endmodule

// File: tb/tb_ram_display_ctrl.sv
// Scoreboard bench for ram_display_ctrl: writes, stepping,
// display scan and reset behaviour.
module tb_ram_display_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic step = 1'b0, we = 1'b0, dir = 1'b0;
  logic auto_inc = 1'b0, view_sel = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] ram_rdata = 16'h12A5;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [3:0]  anode;
  logic [6:0]  seg;

  ram_display_ctrl #(
    .DIGITS(4), .ADDR_W(8), .REFRESH_DIV(4), .DB_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .step(step), .we(we),
    .dir(dir), .auto_inc(auto_inc), .view_sel(view_sel),
    .din(din), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata),
    .anode(anode), .seg(seg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  post;
  } wr_t;

  wr_t sb[$];
  int n_chk = 0, n_fail = 0, n_wr = 0;
  logic post_due = 1'b0;
  logic [7:0] post_addr;

  // Active-low a..g patterns for 0-F.
  logic [6:0] seg_tbl [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (post_due) begin
        chk("we_width", ram_we, 0);
        chk("post_addr", ram_addr, post_addr);
        post_due = 1'b0;
      end else if (ram_we) begin
        n_wr++;
        if (sb.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", ram_addr, e.addr);
          chk("wr_data", ram_wdata, e.data);
          post_addr = e.post;
          post_due = 1'b1;
        end
      end
    end else begin
      post_due = 1'b0;
    end
  end

  task automatic press(input logic s, input logic w);
    step = s;
    we = w;
    repeat (10) @(negedge clock);
    step = 1'b0;
    we = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) press(1'b1, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_anode"}, anode, 4'hF);
    chk({tag, "_seg"}, seg, 7'h7F);
  endtask

  initial begin
    int w0;
    logic [15:0] fr;
    logic [3:0] an, nib;
    int d;
    repeat (2) @(negedge clock);
    chk_reset_vals("rst");

    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("pre_lit_anode", anode, 4'hF);
    end
    @(negedge clock);
    chk("first_lit_anode", anode, 4'hE);
    chk("first_lit_seg", seg, seg_tbl[5]);

    press(1'b1, 1'b0);
    chk("step_once", ram_addr, 8'h01);
    for (int i = 0; i < 20; i++) begin
      step = ~step;
      @(negedge clock);
    end
    step = 1'b0;
    repeat (10) @(negedge clock);
    chk("bounce", ram_addr, 8'h01);

    dir = 1'b1;
    steps(2);
    chk("wrap_down", ram_addr, 8'hFF);
    dir = 1'b0;
    steps(1);
    chk("wrap_up", ram_addr, 8'h00);
    dir = 1'b1;
    steps(1);
    chk("dec_wrap", ram_addr, 8'hFF);

    dir = 1'b0;
    steps(17);
    chk("addr_10", ram_addr, 8'h10);
    din = 16'hBEEF;
    auto_inc = 1'b1;
    sb.push_back('{8'h10, 16'hBEEF, 8'h11});
    press(1'b0, 1'b1);
    chk("auto_inc", ram_addr, 8'h11);

    auto_inc = 1'b0;
    steps(15);
    chk("addr_20", ram_addr, 8'h20);
    din = 16'h5A5A;
    sb.push_back('{8'h20, 16'h5A5A, 8'h20});
    w0 = n_wr;
    press(1'b1, 1'b1);
    chk("simul_addr", ram_addr, 8'h20);
    chk("simul_writes", n_wr - w0, 1);

    steps(28);
    chk("addr_3c", ram_addr, 8'h3C);
    for (int i = 0; i < 40 && anode == 4'hE; i++) @(negedge clock);
    for (int i = 0; i < 40 && anode != 4'hE; i++) @(negedge clock);
    chk("scan_sync", anode, 4'hE);
    for (int i = 0; i < 32; i++) begin
      d = (i / 4) % 4;
      fr = (i < 16) ? 16'h3CA5 : 16'h12A5;
      nib = fr[d*4 +: 4];
      an = ~(4'b0001 << d);
      chk("scan_anode", anode, an);
      chk("scan_seg", seg, seg_tbl[nib]);
      if (i == 8) view_sel = 1'b1;
      @(negedge clock);
    end

    view_sel = 1'b0;
    we = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    we = 1'b0;
    #1;
    chk_reset_vals("arm_rst");
    @(negedge clock);
    reset = 1'b1;
    w0 = n_wr;
    repeat (30) @(negedge clock);
    chk("arm_rst_no_we", n_wr - w0, 0);

    din = 16'h1234;
    we = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (ram_we) break;
    end
    chk("we_seen", ram_we, 1);
    reset = 1'b0;
    we = 1'b0;
    #1;
    chk_reset_vals("we_rst");
    @(negedge clock);
    reset = 1'b1;
    w0 = n_wr;
    repeat (30) @(negedge clock);
    chk("we_rst_no_we", n_wr - w0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end
endmodule
